// File: rtl/ahb_sram_wbuf_ctrl.sv
// AHB slave to single-port SRAM bridge with a one-entry posted-write buffer.
// Define SRAM_WBUF_FWD_EN to forward buffered bytes to matching reads instead of stalling.
module ahb_sram_wbuf_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 14
) (
    input  logic                    hclk,
    input  logic                    hreset,
    input  logic                    hsel,
    input  logic [1:0]              htrans,
    input  logic                    hwrite,
    input  logic [2:0]              hsize,
    input  logic [31:0]             haddr,
    input  logic [DATA_WIDTH-1:0]   hwdata,
    input  logic                    hready_in,
    output logic                    hready_out,
    output logic [1:0]              hresp,
    output logic [DATA_WIDTH-1:0]   hrdata,
    output logic                    sram_cs,
    output logic [DATA_WIDTH/8-1:0] sram_wen,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_RD, S_ERR1, S_ERR2, S_RRD, S_RFIN
    } state_t;

    state_t st, st_nxt;

    logic [ADDR_WIDTH-1:0] ph_addr, wb_addr, haddr_w;
    logic [NB-1:0]         ph_mask, wb_mask, lane_mask;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  wb_valid, wb_hit;
    logic                  acc, size_ok, align_ok, err;
    logic                  rd_acc, wr_acc, rd_req;
    logic                  rdy, ld, drain;
    logic                  unused;

    assign unused  = ^{haddr[31:ADDR_WIDTH+LB], haddr[LB-1:0], htrans[0]};
    assign haddr_w = haddr[ADDR_WIDTH+LB-1:LB];
    assign acc     = hsel & hready_in & htrans[1] & ~hreset;
    assign size_ok = int'(hsize) <= LB;
    assign err     = acc & ~(size_ok & align_ok);
    assign rd_acc  = acc & ~err & ~hwrite;
    assign wr_acc  = acc & ~err & hwrite;
    // raw read request: must not depend on hready_in to avoid a loop
    assign rd_req  = hsel & htrans[1] & ~hwrite;
    assign wb_hit  = wb_valid & (wb_addr == ph_addr);

    always_comb begin
        align_ok  = 1'b1;
        lane_mask = '0;
        for (int i = 0; i < LB; i++) begin
            if (i < int'(hsize) && haddr[i]) align_ok = 1'b0;
        end
        for (int i = 0; i < NB; i++) begin
            if (i >= int'(haddr[LB-1:0]) &&
                i < int'(haddr[LB-1:0]) + (1 << hsize))
                lane_mask[i] = 1'b1;
        end
    end

    always_comb begin
        rdy    = 1'b1;
        hresp  = 2'b00;
        hrdata = '0;
        ld     = 1'b0;
        unique case (st)
            S_WR: begin
                // wbuf still busy with the previous write while a read wants the port
                if (wb_valid && rd_req) rdy = 1'b0;
                else ld = 1'b1;
            end
            S_RD: begin
`ifdef SRAM_WBUF_FWD_EN
                for (int i = 0; i < NB; i++) begin
                    hrdata[8*i +: 8] = (wb_hit && wb_mask[i]) ?
                        wb_data[8*i +: 8] : sram_rdata[8*i +: 8];
                end
`else
                if (wb_hit) rdy = 1'b0;
                else hrdata = sram_rdata;
`endif
            end
            S_ERR1: begin
                rdy   = 1'b0;
                hresp = 2'b01;
            end
            S_ERR2: hresp = 2'b01;
            S_RRD:  rdy = 1'b0;
            S_RFIN: hrdata = sram_rdata;
            default: ;
        endcase
    end

    assign hready_out = rdy;

    always_comb begin
        st_nxt = st;
        if (rdy) begin
            if (err)         st_nxt = S_ERR1;
            else if (wr_acc) st_nxt = S_WR;
            else if (rd_acc) st_nxt = S_RD;
            else             st_nxt = S_IDLE;
        end else begin
            unique case (st)
                S_RD:    st_nxt = S_RRD;
                S_RRD:   st_nxt = S_RFIN;
                S_ERR1:  st_nxt = S_ERR2;
                default: st_nxt = st;
            endcase
        end
    end

    always_comb begin
        sram_cs    = 1'b0;
        sram_wen   = '1;
        sram_addr  = '0;
        sram_wdata = '0;
        drain      = 1'b0;
        if (rd_acc) begin
            sram_cs   = 1'b1;
            sram_addr = haddr_w;
        end else if (st == S_RRD) begin
            sram_cs   = 1'b1;
            sram_addr = ph_addr;
        end else if (wb_valid) begin
            sram_cs    = 1'b1;
            sram_wen   = ~wb_mask;
            sram_addr  = wb_addr;
            sram_wdata = wb_data;
            drain      = 1'b1;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            st       <= S_IDLE;
            ph_addr  <= '0;
            ph_mask  <= '0;
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_mask  <= '0;
            wb_data  <= '0;
        end else begin
            st <= st_nxt;
            if (rd_acc || wr_acc) begin
                ph_addr <= haddr_w;
                ph_mask <= lane_mask;
            end
            // a load in the same cycle as a drain replaces the entry
            if (ld) begin
                wb_valid <= 1'b1;
                wb_addr  <= ph_addr;
                wb_mask  <= ph_mask;
                wb_data  <= hwdata;
            end else if (drain) begin
                wb_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_sram_wbuf_ctrl.sv
// Directed bench for ahb_sram_wbuf_ctrl with a behavioural SRAM.
// Expectations follow SRAM_WBUF_FWD_EN when it is defined.
module tb_ahb_sram_wbuf_ctrl;
    localparam int DW = 32;
    localparam int AW = 14;

    logic          hclk = 1'b0;
    logic          hreset = 1'b1;
    logic          hsel = 1'b0;
    logic [1:0]    htrans = 2'b00;
    logic          hwrite = 1'b0;
    logic [2:0]    hsize = 3'd0;
    logic [31:0]   haddr = 32'd0;
    logic [DW-1:0] hwdata = '0;
    logic          hready_in;
    logic          hready_out;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          sram_cs;
    logic [3:0]    sram_wen;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          first = 1'b1;
    int            n_chk = 0;
    int            n_pass = 0;

    assign hready_in = hready_out;
    always #5 hclk = ~hclk;

    ahb_sram_wbuf_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
        .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp),
        .hrdata(hrdata), .sram_cs(sram_cs), .sram_wen(sram_wen),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata)
    );

    always @(posedge hclk) begin
        if (first) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
            mem[0]     <= 32'hCAFEF00D;
            mem[2]     <= 32'h55667788;
            mem[14'h40] <= 32'h01020304;
            first <= 1'b0;
        end else if (sram_cs) begin
            if (&sram_wen) sram_rdata <= mem[sram_addr];
            else begin
                for (int i = 0; i < 4; i++) begin
                    if (!sram_wen[i])
                        mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ap(input logic w, input logic [2:0] sz,
                      input logic [31:0] a);
        hsel = 1'b1; htrans = 2'b10; hwrite = w; hsize = sz; haddr = a;
    endtask

    task automatic idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'd0;
        haddr = 32'd0;
    endtask

    task automatic nc();
        @(negedge hclk);
    endtask

    initial begin
        // reset
        nc(); #1;
        chk("rst_rdy", hready_out, 1);
        chk("rst_resp", hresp, 0);
        chk("rst_rdata", hrdata, 0);
        chk("rst_cs", sram_cs, 0);
        chk("rst_wen", sram_wen, 4'hF);
        chk("rst_addr", sram_addr, 0);
        chk("rst_wdata", sram_wdata, 0);
        nc(); hreset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nc(); #1;
            chk("idle_rdy", hready_out, 1);
            chk("idle_resp", hresp, 0);
            chk("idle_cs", sram_cs, 0);
            chk("idle_wen", sram_wen, 4'hF);
        end
        nc(); hsel = 1'b1; htrans = 2'b01; #1;
        chk("busy_cs", sram_cs, 0);
        chk("busy_rdy", hready_out, 1);

        // byte write 0xAB @0x101
        nc(); ap(1, 3'd0, 32'h101); #1;
        chk("bw_ap_cs", sram_cs, 0);
        nc(); idle(); hwdata = 32'h0000AB00; #1;
        chk("bw_dp_rdy", hready_out, 1);
        chk("bw_dp_cs", sram_cs, 0);
        nc(); hwdata = '0; #1;
        chk("bw_dr_cs", sram_cs, 1);
        chk("bw_dr_addr", sram_addr, 14'h40);
        chk("bw_dr_wen", sram_wen, 4'b1101);
        chk("bw_dr_byte", sram_wdata[15:8], 8'hAB);
        nc(); #1;
        chk("bw_after_cs", sram_cs, 0);
        nc(); ap(0, 3'd2, 32'h100); #1;
        chk("rb40_cs", sram_cs, 1);
        chk("rb40_wen", sram_wen, 4'hF);
        nc(); idle(); #1;
        chk("rb40_data", hrdata, 32'h0102AB04);

        // misaligned half write
        nc(); ap(1, 3'd1, 32'h3); #1;
        chk("mis_ap_cs", sram_cs, 0);
        nc(); idle(); hwdata = 32'hFFFFFFFF; #1;
        chk("mis_e1_rdy", hready_out, 0);
        chk("mis_e1_resp", hresp, 2'b01);
        chk("mis_e1_cs", sram_cs, 0);
        nc(); #1;
        chk("mis_e2_rdy", hready_out, 1);
        chk("mis_e2_resp", hresp, 2'b01);
        chk("mis_e2_cs", sram_cs, 0);
        nc(); ap(0, 3'd2, 32'h0); #1;
        chk("mis_rd_cs", sram_cs, 1);
        chk("mis_rd_addr", sram_addr, 0);
        nc(); idle(); #1;
        chk("mis_rd_data", hrdata, 32'hCAFEF00D);
        chk("mis_rd_resp", hresp, 0);

        // oversize transfer
        nc(); ap(1, 3'd3, 32'h0); #1;
        nc(); idle(); #1;
        chk("big_e1_rdy", hready_out, 0);
        chk("big_e1_resp", hresp, 2'b01);
        nc(); #1;
        chk("big_e2_rdy", hready_out, 1);
        chk("big_e2_resp", hresp, 2'b01);
        nc(); #1;
        chk("big_ok_resp", hresp, 0);

        // write then read same word
        nc(); ap(1, 3'd2, 32'h0); #1;
        nc(); ap(0, 3'd2, 32'h0); hwdata = 32'h11223344; #1;
        chk("wr_rdy", hready_out, 1);
        chk("wr_rd_cs", sram_cs, 1);
        chk("wr_rd_wen", sram_wen, 4'hF);
        nc(); idle(); hwdata = '0; #1;
`ifdef SRAM_WBUF_FWD_EN
        chk("wr_fwd_rdy", hready_out, 1);
        chk("wr_fwd_data", hrdata, 32'h11223344);
        chk("wr_fwd_dr_wen", sram_wen, 4'h0);
`else
        chk("wr_d1_rdy", hready_out, 0);
        chk("wr_d1_wen", sram_wen, 4'h0);
        chk("wr_d1_wdata", sram_wdata, 32'h11223344);
        nc(); #1;
        chk("wr_d2_rdy", hready_out, 0);
        chk("wr_d2_cs", sram_cs, 1);
        chk("wr_d2_wen", sram_wen, 4'hF);
        nc(); #1;
        chk("wr_d3_rdy", hready_out, 1);
        chk("wr_d3_data", hrdata, 32'h11223344);
`endif

        // W1, W2, R back to back
        nc(); ap(1, 3'd2, 32'h0); #1;
        nc(); ap(1, 3'd2, 32'h4); hwdata = 32'hA1A1A1A1; #1;
        chk("bb_w1dp_rdy", hready_out, 1);
        chk("bb_w1dp_cs", sram_cs, 0);
        nc(); ap(0, 3'd2, 32'h8); hwdata = 32'hB2B2B2B2; #1;
        chk("bb_stall_rdy", hready_out, 0);
        chk("bb_stall_cs", sram_cs, 1);
        chk("bb_stall_wen", sram_wen, 4'h0);
        chk("bb_stall_addr", sram_addr, 0);
        chk("bb_stall_wdata", sram_wdata, 32'hA1A1A1A1);
        nc(); #1;
        chk("bb_rd_rdy", hready_out, 1);
        chk("bb_rd_wen", sram_wen, 4'hF);
        chk("bb_rd_addr", sram_addr, 2);
        nc(); idle(); hwdata = '0; #1;
        chk("bb_rd_data", hrdata, 32'h55667788);
        chk("bb_w2_wen", sram_wen, 4'h0);
        chk("bb_w2_addr", sram_addr, 1);
        chk("bb_w2_wdata", sram_wdata, 32'hB2B2B2B2);
        nc(); #1;
        chk("bb_end_cs", sram_cs, 0);

        // pending byte write then word read of same word
        nc(); ap(1, 3'd0, 32'h2); #1;
        nc(); ap(0, 3'd2, 32'h0); hwdata = 32'h00EE0000; #1;
        chk("pb_rd_cs", sram_cs, 1);
        nc(); idle(); hwdata = '0; #1;
`ifdef SRAM_WBUF_FWD_EN
        chk("pb_fwd_rdy", hready_out, 1);
        chk("pb_fwd_data", hrdata, 32'hA1EEA1A1);
        chk("pb_dr_wen", sram_wen, 4'b1011);
`else
        chk("pb_d1_rdy", hready_out, 0);
        chk("pb_d1_wen", sram_wen, 4'b1011);
        nc(); #1;
        chk("pb_d2_rdy", hready_out, 0);
        chk("pb_d2_wen", sram_wen, 4'hF);
        nc(); #1;
        chk("pb_d3_rdy", hready_out, 1);
        chk("pb_d3_data", hrdata, 32'hA1EEA1A1);
`endif

        // reset during a write data phase
        nc(); ap(1, 3'd2, 32'h10); #1;
        nc(); idle(); hreset = 1'b1; hwdata = 32'hDEADBEEF; #1;
        nc(); hreset = 1'b0; hwdata = '0; #1;
        chk("mrst_cs", sram_cs, 0);
        chk("mrst_rdy", hready_out, 1);
        chk("mrst_wen", sram_wen, 4'hF);
        nc(); #1;
        chk("mrst_nodrain", sram_cs, 0);
        nc(); ap(0, 3'd2, 32'h10); #1;
        chk("mrst_rd_addr", sram_addr, 4);
        nc(); idle(); #1;
        chk("mrst_rd_data", hrdata, 0);
        nc(); #1;
        chk("mrst_idle_rdata", hrdata, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ahb_sram_wbuf_ctrl.md
Name: ahb_sram_wbuf_ctrl

Overview:
Parametrised AHB-to-single-port-SRAM write controller for the SRAM subsystem. It generalises byte-lane write-enable generation to DATA_WIDTH-wide buses, adding alignment/size checking and a one-entry posted-write buffer. The buffer resolves the write-data-phase versus read-address-phase port conflict, with optional read forwarding. It sits between the AHB slave interface and the SRAM macro.

Parameters:
DATA_WIDTH, 32, bus and SRAM width; 32 or 64. NB = DATA_WIDTH/8 lanes; LB = log2(NB).
ADDR_WIDTH, 14, SRAM word-address width; sram_addr = haddr[ADDR_WIDTH+LB-1:LB].

Ports:
hclk  in  1  clock
hreset  in  1  reset
hsel  in  1  slave select
htrans  in  2  AHB transfer type
hwrite  in  1  1 = write
hsize  in  3  AHB size
haddr  in  32  byte address
hwdata  in  DATA_WIDTH  write data (data phase)
hready_in  in  1  bus ready
hready_out  out  1  slave ready
hresp  out  2  00 OKAY, 01 ERROR
hrdata  out  DATA_WIDTH  read data
sram_cs  out  1  SRAM chip select, active high
sram_wen  out  NB  per-lane write enable, active low (0 = write lane)
sram_addr  out  ADDR_WIDTH  SRAM word address
sram_wdata  out  DATA_WIDTH  SRAM write data
sram_rdata  in  DATA_WIDTH  SRAM read data, valid the cycle after a read cs

Behaviour:
- Single clock hclk; hreset is synchronous, active-high.
- Reset values: hready_out=1, hresp=00, hrdata=0, sram_cs=0, sram_wen=all 1s, sram_addr=0, sram_wdata=0. The buffer is cleared (wbuf_valid=0); a pending posted write is discarded.
- Accept condition: hsel & hready_in & htrans[1]. IDLE, BUSY or unselected transfers get an OKAY zero-wait response with no SRAM activity.
- Lane mask: 2^hsize lanes starting at haddr[LB-1:0].
  - Example (DATA_WIDTH=32): byte @1 -> wen 1101; half @2 -> 0011; word -> 0000.
- Error: if hsize > LB, or haddr is not a multiple of 2^hsize, the transfer gets a two-cycle ERROR.
  - Cycle 1: hready_out=0, hresp=01. Cycle 2: hready_out=1, hresp=01.
  - No SRAM access and no buffer load occur.
- Read address phase: sram_cs=1, sram_wen all 1s, sram_addr driven from haddr in the same cycle. Read data phase: hrdata = sram_rdata (merged per forwarding rule), zero wait.
- Write address phase: register word address and lane mask. Write data phase: hwdata is loaded into wbuf at the end of the cycle.
- Drain: when wbuf_valid and no read is accepted this cycle, sram_cs=1, sram_wen=~mask, sram_addr/sram_wdata from wbuf; wbuf_valid clears. A read address phase has priority over drain.
- Back-to-back writes followed by a read (W1, W2, R): in W2's data phase wbuf still holds W1.
  - If no read is presented, W1 drains and W2 loads in the same cycle.
  - If a read address is presented, hready_out=0 for one cycle and W1 drains. The next cycle W2 loads, hready_out=1 and the read is accepted.
- hrdata is 0 outside read data phases. Lanes not in the mask are never written.
- Reset asserted mid-transfer: the next cycle shows reset values; the in-flight transfer is abandoned.

Optional Feature:
SRAM_WBUF_FWD_EN
- Defined: a read whose word address matches a valid wbuf returns, per lane, the wbuf byte where the mask is set and the sram_rdata byte elsewhere. Zero wait.
- Undefined: a matching read inserts two wait states.
  - D1: hready_out=0, wbuf drains.
  - D2: hready_out=0, SRAM re-read at the registered address.
  - D3: hready_out=1, hrdata = sram_rdata.

Test Plan:
- Reset then idle: hready_out=1, hresp=00, sram_wen=4'b1111, sram_cs=0 throughout.
- Byte write 0xAB to 0x101, then idle: drain cycle shows sram_addr=0x40, sram_wen=1101, sram_wdata[15:8]=0xAB.
- Half write with haddr=0x3: ERROR sequence (hready 0/01, then 1/01), no sram_cs, later read of word 0 unchanged.
- W 0x11223344 to 0x0, immediately R 0x0:
  - With FWD_EN: hrdata=0x11223344 zero wait.
  - Without: 2 wait states, same data.
- W1 @0x0, W2 @0x4, R @0x8 back-to-back: one wait state in W2 data phase; W1 drains there; R returns the SRAM value; W2 drains after.
- Byte write to 0x2 pending, then word read of 0x0 with FWD_EN: byte 2 comes from wbuf, others from SRAM.
